// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: immediate-extension mode encoding used by
// the instruction decoder and the immediate-extension unit.
package mips_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'd0,
        EXT_ZERO   = 2'd1,
        EXT_UPPER  = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_e;

    localparam int unsigned IMM_FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper (LUI) and branch-offset forms.
module imm_ext_core
    import mips_pkg::*;
#(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]  imm_i,
    input  ext_mode_e        mode_i,
    output logic [OUT_W-1:0] ext_o
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] branch;

    // A zero-width replication is illegal, so the full-width case is split out.
    if (IN_W == OUT_W) begin : g_full
        assign sext  = imm_i;
        assign zext  = imm_i;
        assign upper = imm_i;
    end else begin : g_narrow
        assign sext  = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
        assign zext  = {{(OUT_W-IN_W){1'b0}}, imm_i};
        assign upper = {imm_i, {(OUT_W-IN_W){1'b0}}};
    end

    assign branch = sext << BR_SHIFT;

    always_comb begin
        ext_o = sext;
        case (mode_i)
            EXT_SIGN:   ext_o = sext;
            EXT_ZERO:   ext_o = zext;
            EXT_UPPER:  ext_o = upper;
            EXT_BRANCH: ext_o = branch;
            default:    ext_o = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Buffered immediate-extension unit: extends on accept and queues {data, tag}
// in a 2-entry FIFO feeding the ALU-B mux and branch-target adder.
module imm_extend_unit
    import mips_pkg::*;
#(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned BR_SHIFT = 2,
    parameter int unsigned TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_count
);

    logic [OUT_W-1:0] ext_data;

    logic [OUT_W-1:0] data_q [IMM_FIFO_DEPTH];
    logic [OUT_W-1:0] data_d [IMM_FIFO_DEPTH];
    logic [TAG_W-1:0] tag_q  [IMM_FIFO_DEPTH];
    logic [TAG_W-1:0] tag_d  [IMM_FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             push;
    logic             pop;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .imm_i  (in_imm),
        .mode_i (ext_mode_e'(in_mode)),
        .ext_o  (ext_data)
    );

    // Handshake depends only on registered occupancy: no out_ready -> in_ready path.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            data_d[wr_ptr_q] = ext_data;
            tag_d[wr_ptr_q]  = in_tag;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IMM_FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            data_q   <= data_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_data  = data_q[rd_ptr_q];
    assign out_tag   = tag_q[rd_ptr_q];
    assign out_count = count_q;

endmodule
